comparator_axil_slave: RTL and testbench

COMPARATOR_AXIL_SLAVE -- requirements
Module: comparator_axil_slave

---
 rtl/comparator_axil_slave.sv | 205 ++++++++++++++++++++
 tb/tb_comparator_axil_slave.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comparator_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : comparator_axil_slave
// Purpose  : AXI4-Lite slave with four 32-bit registers REG0..REG3 and a
//            registered magnitude comparison of REG0 against REG1.
//            REG2[0] selects unsigned (0) or two's-complement signed (1)
//            comparison. REG2[31:1] and REG3 are scratch storage.
// Ports    : ACLK, ARESET (synchronous, active-high)
//            S_AXI_AW* / S_AXI_W* / S_AXI_B* : write address, data, response
//            S_AXI_AR* / S_AXI_R*            : read address, data
//            cmp_gt, cmp_eq, cmp_lt          : one-hot comparison result
// Config   : define COMPARATOR_AXIL_WSTRB_EN to honour per-byte WSTRB;
//            otherwise every accepted write updates all 32 bits.
// Revision : 1.0 - initial release
// ============================================================================
module comparator_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            cmp_gt,
    output logic                            cmp_eq,
    output logic                            cmp_lt
);

    typedef enum logic [0:0] {W_IDLE = 1'b0, W_RESP = 1'b1} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    wstate_t r_wstate, w_wstate_next;
    rstate_t r_rstate, w_rstate_next;

    logic [C_S_AXI_DATA_WIDTH-1:0] r_regs [0:3];
    logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
    logic [C_S_AXI_DATA_WIDTH-1:0] w_wr_value;
    logic [1:0]                    w_widx;
    logic [1:0]                    w_ridx;
    logic                          w_wr_hs;
    logic                          w_rd_hs;
    logic                          r_cmp_gt, r_cmp_eq, r_cmp_lt;
    logic                          w_gt, w_lt, w_eq;

    assign w_widx = S_AXI_AWADDR[3:2];
    assign w_ridx = S_AXI_ARADDR[3:2];

    // ---------------- write FSM ----------------
    // Ready is only offered when both address and data are present, so
    // address and data are always accepted on the same edge.
    always_comb begin
        w_wstate_next = r_wstate;
        w_wr_hs       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (S_AXI_AWVALID && S_AXI_WVALID && !ARESET) begin
                    w_wr_hs       = 1'b1;
                    w_wstate_next = W_RESP;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    w_wstate_next = W_IDLE;
                end
            end
            default: w_wstate_next = W_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_wstate <= W_IDLE;
        end else begin
            r_wstate <= w_wstate_next;
        end
    end

    assign S_AXI_AWREADY = w_wr_hs;
    assign S_AXI_WREADY  = w_wr_hs;
    assign S_AXI_BVALID  = (r_wstate == W_RESP);
    assign S_AXI_BRESP   = 2'b00;

    // ---------------- write data merge ----------------
`ifdef COMPARATOR_AXIL_WSTRB_EN
    always_comb begin
        w_wr_value = r_regs[w_widx];
        for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
            if (S_AXI_WSTRB[b]) begin
                w_wr_value[8*b +: 8] = S_AXI_WDATA[8*b +: 8];
            end
        end
    end
`else
    assign w_wr_value = S_AXI_WDATA;
`endif

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            for (int i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wr_hs) begin
            r_regs[w_widx] <= w_wr_value;
        end
    end

    // ---------------- read FSM ----------------
    always_comb begin
        w_rstate_next = r_rstate;
        w_rd_hs       = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (S_AXI_ARVALID && !ARESET) begin
                    w_rd_hs       = 1'b1;
                    w_rstate_next = R_DATA;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    w_rstate_next = R_IDLE;
                end
            end
            default: w_rstate_next = R_IDLE;
        endcase
    end

    // The read samples r_regs at the same edge a write may update it, so a
    // colliding read naturally returns the pre-write contents. The data
    // register is cleared when the beat completes so RDATA idles at zero.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_rstate <= R_IDLE;
            r_rdata  <= '0;
        end else begin
            r_rstate <= w_rstate_next;
            if (w_rd_hs) begin
                r_rdata <= r_regs[w_ridx];
            end else if ((r_rstate == R_DATA) && S_AXI_RREADY) begin
                r_rdata <= '0;
            end
        end
    end

    assign S_AXI_ARREADY = w_rd_hs;
    assign S_AXI_RVALID  = (r_rstate == R_DATA);
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;

    // ---------------- comparator ----------------
    always_comb begin
        w_eq = (r_regs[0] == r_regs[1]);
        if (r_regs[2][0]) begin
            w_gt = ($signed(r_regs[0]) > $signed(r_regs[1]));
            w_lt = ($signed(r_regs[0]) < $signed(r_regs[1]));
        end else begin
            w_gt = (r_regs[0] > r_regs[1]);
            w_lt = (r_regs[0] < r_regs[1]);
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            r_cmp_gt <= 1'b0;
            r_cmp_eq <= 1'b1;
            r_cmp_lt <= 1'b0;
        end else begin
            r_cmp_gt <= w_gt;
            r_cmp_eq <= w_eq;
            r_cmp_lt <= w_lt;
        end
    end

    assign cmp_gt = r_cmp_gt;
    assign cmp_eq = r_cmp_eq;
    assign cmp_lt = r_cmp_lt;

    // Inputs that carry no meaning for this register map.
    logic w_unused;
`ifdef COMPARATOR_AXIL_WSTRB_EN
    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_WSTRB};
`endif

endmodule
`default_nettype wire

// File: tb/tb_comparator_axil_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparator_axil_slave
// Purpose  : Directed self-checking bench for comparator_axil_slave.
//            Honours COMPARATOR_AXIL_WSTRB_EN when computing byte-strobe
//            expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparator_axil_slave;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [3:0]  S_AXI_AWADDR;
    logic [2:0]  S_AXI_AWPROT;
    logic        S_AXI_AWVALID;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA;
    logic [3:0]  S_AXI_WSTRB;
    logic        S_AXI_WVALID;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY;
    logic [3:0]  S_AXI_ARADDR;
    logic [2:0]  S_AXI_ARPROT;
    logic        S_AXI_ARVALID;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY;
    logic        cmp_gt, cmp_eq, cmp_lt;

    int tests = 0;
    int fails = 0;

    comparator_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .cmp_gt(cmp_gt), .cmp_eq(cmp_eq), .cmp_lt(cmp_lt)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Inputs change 1ns after a rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Bus transaction helpers: they only move the handshakes and report
    // what they saw; the test tasks do the comparing.
    task automatic axi_write(input logic [3:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp,
                             output logic ok);
        logic got;
        ok   = 1'b0;
        got  = 1'b0;
        resp = 2'bxx;
        S_AXI_AWADDR  = a;
        S_AXI_WDATA   = d;
        S_AXI_WSTRB   = s;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (S_AXI_AWREADY && S_AXI_WREADY) got = 1'b1;
            @(posedge ACLK);
            #1;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        if (got) begin
            for (int i = 0; i < 20 && !ok; i++) begin
                if (S_AXI_BVALID) begin
                    resp = S_AXI_BRESP;
                    S_AXI_BREADY = 1'b1;
                    ok = 1'b1;
                end
                tick();
            end
            S_AXI_BREADY = 1'b0;
        end
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d,
                            output logic [1:0] resp, output logic ok);
        logic got;
        ok   = 1'b0;
        got  = 1'b0;
        d    = 'x;
        resp = 2'bxx;
        S_AXI_ARADDR  = a;
        S_AXI_ARVALID = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            #1;
            if (S_AXI_ARREADY) got = 1'b1;
            @(posedge ACLK);
            #1;
        end
        S_AXI_ARVALID = 1'b0;
        if (got) begin
            for (int i = 0; i < 20 && !ok; i++) begin
                if (S_AXI_RVALID) begin
                    d    = S_AXI_RDATA;
                    resp = S_AXI_RRESP;
                    S_AXI_RREADY = 1'b1;
                    ok = 1'b1;
                end
                tick();
            end
            S_AXI_RREADY = 1'b0;
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        repeat (2) tick();
        #1;
        tests++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b000) begin
            fails++;
            $display("FAIL reset_ready: got %b want 000",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        tests++;
        if ({S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA} !== 34'd0) begin
            fails++;
            $display("FAIL reset_valid: bvalid=%b rvalid=%b rdata=%h want 0 0 0",
                     S_AXI_BVALID, S_AXI_RVALID, S_AXI_RDATA);
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        tick();
        ARESET = 1'b0;
        tests++;
        if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b010) begin
            fails++;
            $display("FAIL reset_cmp: gt/eq/lt=%b want 010", {cmp_gt, cmp_eq, cmp_lt});
        end
    endtask

    task automatic test_basic_rw();
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        logic [3:0]  addrs [4] = '{4'h0, 4'h4, 4'h8, 4'hC};
        for (int i = 0; i < 4; i++) begin
            axi_write(addrs[i], 32'(i + 1), 4'hF, r, ok);
            tests++;
            if (!ok || r !== 2'b00) begin
                fails++;
                $display("FAIL basic_wr%0d: ok=%b bresp=%b want 1 00", i, ok, r);
            end
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(addrs[i], d, r, ok);
            tests++;
            if (!ok || r !== 2'b00 || d !== 32'(i + 1)) begin
                fails++;
                $display("FAIL basic_rd%0d: ok=%b rresp=%b rdata=%h want 1 00 %h",
                         i, ok, r, d, 32'(i + 1));
            end
        end
        tests++;
        if (S_AXI_RVALID !== 1'b0 || S_AXI_RDATA !== 32'd0) begin
            fails++;
            $display("FAIL rdata_idle: rvalid=%b rdata=%h want 0 0", S_AXI_RVALID, S_AXI_RDATA);
        end
        // Low address bits are ignored.
        axi_write(4'hD, 32'h0000_0077, 4'hF, r, ok);
        axi_read(4'hF, d, r, ok);
        tests++;
        if (!ok || d !== 32'h0000_0077) begin
            fails++;
            $display("FAIL addr_lsb: ok=%b rdata=%h want 1 00000077", ok, d);
        end
    endtask

    task automatic test_aw_wait();
        logic        bad;
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        bad = 1'b0;
        S_AXI_AWADDR  = 4'hC;
        S_AXI_WDATA   = 32'hCAFE_0003;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (S_AXI_AWREADY || S_AXI_WREADY) bad = 1'b1;
            tick();
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL aw_only_ready: ready seen high=%b want 0", bad);
        end
        // Data alone must wait as well.
        bad = 1'b0;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (S_AXI_AWREADY || S_AXI_WREADY) bad = 1'b1;
            tick();
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL w_only_ready: ready seen high=%b want 0", bad);
        end
        S_AXI_AWVALID = 1'b1;
        #1;
        tests++;
        if ({S_AXI_AWREADY, S_AXI_WREADY} !== 2'b11) begin
            fails++;
            $display("FAIL aw_w_ready: got %b want 11", {S_AXI_AWREADY, S_AXI_WREADY});
        end
        tick();
        tests++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID} !== 3'b001) begin
            fails++;
            $display("FAIL ready_one_cycle: aw/w/bvalid=%b want 001",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID});
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (S_AXI_BVALID !== 1'b1 || S_AXI_BRESP !== 2'b00) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL bvalid_hold: dropped=%b want 0", bad);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        tests++;
        if (S_AXI_BVALID !== 1'b0) begin
            fails++;
            $display("FAIL bvalid_clear: got %b want 0", S_AXI_BVALID);
        end
        axi_read(4'hC, d, r, ok);
        tests++;
        if (!ok || d !== 32'hCAFE_0003) begin
            fails++;
            $display("FAIL aw_wait_data: ok=%b rdata=%h want 1 cafe0003", ok, d);
        end
    endtask

    task automatic test_compare();
        logic [1:0] r;
        logic       ok;
        axi_write(4'h8, 32'h0, 4'hF, r, ok);
        axi_write(4'h0, 32'hFFFF_FFFF, 4'hF, r, ok);
        axi_write(4'h4, 32'h1, 4'hF, r, ok);
        tests++;
        if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b100) begin
            fails++;
            $display("FAIL cmp_unsigned_gt: gt/eq/lt=%b want 100", {cmp_gt, cmp_eq, cmp_lt});
        end
        // Switch to signed and check the result lands one cycle after commit.
        S_AXI_AWADDR  = 4'h8;
        S_AXI_WDATA   = 32'h1;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        tests++;
        if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b100) begin
            fails++;
            $display("FAIL cmp_latency_early: gt/eq/lt=%b want 100", {cmp_gt, cmp_eq, cmp_lt});
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        tests++;
        if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b001) begin
            fails++;
            $display("FAIL cmp_signed_lt: gt/eq/lt=%b want 001", {cmp_gt, cmp_eq, cmp_lt});
        end
        axi_write(4'h4, 32'hFFFF_FFFF, 4'hF, r, ok);
        tests++;
        if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b010) begin
            fails++;
            $display("FAIL cmp_eq: gt/eq/lt=%b want 010", {cmp_gt, cmp_eq, cmp_lt});
        end
        axi_write(4'h0, 32'h1, 4'hF, r, ok);
        tests++;
        if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b100) begin
            fails++;
            $display("FAIL cmp_signed_gt: gt/eq/lt=%b want 100", {cmp_gt, cmp_eq, cmp_lt});
        end
        axi_write(4'h8, 32'hFFFF_FFFE, 4'hF, r, ok);
        tests++;
        if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b001) begin
            fails++;
            $display("FAIL cmp_unsigned_lt: gt/eq/lt=%b want 001", {cmp_gt, cmp_eq, cmp_lt});
        end
    endtask

    task automatic test_wstrb();
        logic [31:0] d;
        logic [31:0] exp;
        logic [1:0]  r;
        logic        ok;
`ifdef COMPARATOR_AXIL_WSTRB_EN
        exp = 32'hAA22_CC44;
`else
        exp = 32'h1122_3344;
`endif
        axi_write(4'h4, 32'hAABB_CCDD, 4'hF, r, ok);
        axi_write(4'h4, 32'h1122_3344, 4'b0101, r, ok);
        axi_read(4'h4, d, r, ok);
        tests++;
        if (!ok || d !== exp) begin
            fails++;
            $display("FAIL wstrb: ok=%b rdata=%h want 1 %h", ok, d, exp);
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        axi_write(4'h8, 32'h3, 4'hF, r, ok);
        S_AXI_AWADDR  = 4'h8;
        S_AXI_WDATA   = 32'h55;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 4'h8;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        #1;
        tests++;
        if ({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY} !== 3'b111) begin
            fails++;
            $display("FAIL same_cycle_ready: got %b want 111",
                     {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY});
        end
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        tests++;
        if ({S_AXI_BVALID, S_AXI_RVALID} !== 2'b11 || S_AXI_RDATA !== 32'h3) begin
            fails++;
            $display("FAIL same_cycle_old: b/rvalid=%b rdata=%h want 11 00000003",
                     {S_AXI_BVALID, S_AXI_RVALID}, S_AXI_RDATA);
        end
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        axi_read(4'h8, d, r, ok);
        tests++;
        if (!ok || d !== 32'h55) begin
            fails++;
            $display("FAIL same_cycle_new: ok=%b rdata=%h want 1 00000055", ok, d);
        end
    endtask

    task automatic test_reset_inflight();
        logic        bad;
        logic [31:0] d;
        logic [1:0]  r;
        logic        ok;
        S_AXI_AWADDR  = 4'h0;
        S_AXI_WDATA   = 32'h1234;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        tick();
        S_AXI_WVALID  = 1'b0;
        // A second, uncommitted write address is left pending into reset.
        S_AXI_AWADDR  = 4'h4;
        S_AXI_WDATA   = 32'h99;
        tests++;
        if (S_AXI_BVALID !== 1'b1) begin
            fails++;
            $display("FAIL inflight_bvalid: got %b want 1", S_AXI_BVALID);
        end
        ARESET = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        tests++;
        if (S_AXI_BVALID !== 1'b0) begin
            fails++;
            $display("FAIL reset_drop_bvalid: got %b want 0", S_AXI_BVALID);
        end
        ARESET = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (S_AXI_BVALID !== 1'b0) bad = 1'b1;
        end
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL reset_no_resp: late bvalid=%b want 0", bad);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), d, r, ok);
            tests++;
            if (!ok || d !== 32'd0) begin
                fails++;
                $display("FAIL reset_reg%0d: ok=%b rdata=%h want 1 00000000", i, ok, d);
            end
        end
        tests++;
        if ({cmp_gt, cmp_eq, cmp_lt} !== 3'b010) begin
            fails++;
            $display("FAIL reset_cmp_after: gt/eq/lt=%b want 010", {cmp_gt, cmp_eq, cmp_lt});
        end
    endtask

    initial begin
        ARESET        = 1'b1;
        S_AXI_AWADDR  = '0;
        S_AXI_AWPROT  = 3'b000;
        S_AXI_AWVALID = 1'b0;
        S_AXI_WDATA   = '0;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_WVALID  = 1'b0;
        S_AXI_BREADY  = 1'b0;
        S_AXI_ARADDR  = '0;
        S_AXI_ARPROT  = 3'b000;
        S_AXI_ARVALID = 1'b0;
        S_AXI_RREADY  = 1'b0;
        test_reset();
        test_basic_rw();
        test_aw_wait();
        test_compare();
        test_wstrb();
        test_same_cycle();
        test_reset_inflight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
